// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory stage between execute and the mem/wb register.
// Runs LW/SW single transfers and LM/SM bursts over a ready-handshaked
// data-memory port, and passes non-memory ops through in one cycle.
// Ports: clk, reset (async, active-low); in_* execute result; stall to
// upstream; dmem_* memory request port; rf_rd_* register read for SM data;
// out_* mem/wb entry; bus_err sticky timeout flag.
// Optional: define MEM_STAGE_TIMEOUT_EN to drop requests that wait
// WAIT_LIMIT cycles for dmem_ready (bus_err is tied to 0 otherwise).
// Opcode field in_op[5:2]: ADD 0000, ADI 0001, NDU 0010 (ALU ops),
// LW 0100, SW 0101, LM 0110, SM 0111; anything else passes through
// without a register write.
module mem_stage_ctrl #(
    parameter int DATA_W     = 16,
    parameter int WAIT_LIMIT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [5:0]        in_op,
    input  logic [2:0]        in_regA,
    input  logic [2:0]        in_regC,
    input  logic [7:0]        in_imm8,
    input  logic [DATA_W-1:0] in_alu_out,
    input  logic [DATA_W-1:0] in_ra_out,
    input  logic              in_ccr_write,
    input  logic [1:0]        in_ccr_value,
    output logic              stall,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic              dmem_re,
    output logic              dmem_we,
    input  logic              dmem_ready,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [2:0]        rf_rd_addr,
    input  logic [DATA_W-1:0] rf_rd_data,
    output logic              out_valid,
    output logic [5:0]        out_op,
    output logic [2:0]        out_dest,
    output logic [DATA_W-1:0] out_wdata,
    output logic              out_rf_write,
    output logic              out_ccr_write,
    output logic [1:0]        out_ccr_value,
    output logic              bus_err
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_ADI = 4'b0001;
    localparam logic [3:0] OP_NDU = 4'b0010;
    localparam logic [3:0] OP_LW  = 4'b0100;
    localparam logic [3:0] OP_SW  = 4'b0101;
    localparam logic [3:0] OP_LM  = 4'b0110;
    localparam logic [3:0] OP_SM  = 4'b0111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_MULTI
    } state_t;

    state_t state, state_nxt;

    logic [3:0] opc;
    logic       is_lw, is_sw, is_lm, is_sm, is_alu;
    logic       acc_go, pass_go, xfer_done, expire;

    logic [5:0]        cur_op;
    logic              cur_load;
    logic [DATA_W-1:0] cur_addr;
    logic [7:0]        pend;
    logic [2:0]        cur_rega;
    logic              cur_carry;
    logic [DATA_W-1:0] sw_data;
    logic [2:0]        idx;
    logic              last;

    assign opc    = in_op[5:2];
    assign is_lw  = opc == OP_LW;
    assign is_sw  = opc == OP_SW;
    assign is_lm  = opc == OP_LM;
    assign is_sm  = opc == OP_SM;
    assign is_alu = opc == OP_ADD || opc == OP_ADI || opc == OP_NDU;

    assign acc_go  = state == S_IDLE && in_valid;
    // Everything that does not start a memory access retires next cycle,
    // including LM/SM with an empty mask (a bubble entry).
    assign pass_go = acc_go && !(is_lw || is_sw)
                   && !((is_lm || is_sm) && |in_imm8);
    assign xfer_done = state != S_IDLE && dmem_ready;

    // Next register of an LM/SM burst: lowest set bit still pending.
    always_comb begin
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (pend[i]) idx = 3'(i);
        end
    end

    assign last = (pend & ~(8'd1 << idx)) == 8'd0;

`ifdef MEM_STAGE_TIMEOUT_EN
    localparam int WCNT_W = $clog2(WAIT_LIMIT + 1);

    logic [WCNT_W-1:0] wait_cnt;
    logic              bus_err_q;

    assign expire = stall && !dmem_ready
                  && wait_cnt == WCNT_W'(WAIT_LIMIT - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt  <= '0;
            bus_err_q <= 1'b0;
        end else begin
            if (!stall || dmem_ready || expire) wait_cnt <= '0;
            else wait_cnt <= wait_cnt + WCNT_W'(1);
            if (expire) bus_err_q <= 1'b1;
        end
    end

    assign bus_err = bus_err_q;
`else
    logic unused_cfg;

    assign unused_cfg = ^WAIT_LIMIT;
    assign expire     = 1'b0;
    assign bus_err    = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (acc_go && (is_lw || is_sw))
                    state_nxt = S_ACCESS;
                else if (acc_go && (is_lm || is_sm) && |in_imm8)
                    state_nxt = S_MULTI;
            end
            S_ACCESS: begin
                if (dmem_ready || expire) state_nxt = S_IDLE;
            end
            S_MULTI: begin
                if (expire || (dmem_ready && last))
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        stall      = state != S_IDLE;
        dmem_re    = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        rf_rd_addr = 3'd0;
        unique case (state)
            S_ACCESS: begin
                dmem_addr = cur_addr;
                dmem_re   = cur_load;
                dmem_we   = !cur_load;
                if (!cur_load) dmem_wdata = sw_data;
            end
            S_MULTI: begin
                dmem_addr = cur_addr;
                dmem_re   = cur_load;
                dmem_we   = !cur_load;
                if (!cur_load) begin
                    rf_rd_addr = idx;
                    dmem_wdata = rf_rd_data;
                end
            end
            default: ;
        endcase
    end

    // The accepted op is captured here: while stalled, in_* already
    // belongs to the next instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_op    <= '0;
            cur_load  <= 1'b0;
            cur_addr  <= '0;
            pend      <= '0;
            cur_rega  <= '0;
            cur_carry <= 1'b0;
            sw_data   <= '0;
        end else if (acc_go) begin
            cur_op    <= in_op;
            cur_load  <= is_lw || is_lm;
            cur_addr  <= in_alu_out;
            pend      <= in_imm8;
            cur_rega  <= in_regA;
            cur_carry <= in_ccr_value[0];
            sw_data   <= in_ra_out;
        end else if (state == S_MULTI && dmem_ready) begin
            pend[idx] <= 1'b0;
            cur_addr  <= cur_addr + DATA_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid     <= 1'b0;
            out_op        <= '0;
            out_dest      <= '0;
            out_wdata     <= '0;
            out_rf_write  <= 1'b0;
            out_ccr_write <= 1'b1;
            out_ccr_value <= '0;
        end else begin
            out_valid <= 1'b0;
            unique case (1'b1)
                pass_go: begin
                    out_valid    <= 1'b1;
                    out_op       <= in_op;
                    out_wdata    <= in_alu_out;
                    out_rf_write <= is_alu;
                    if (is_lm || is_sm) begin
                        out_dest      <= in_regA;
                        out_ccr_write <= 1'b1;
                        out_ccr_value <= '0;
                    end else begin
                        out_dest      <= in_regC;
                        out_ccr_write <= in_ccr_write;
                        out_ccr_value <= in_ccr_value;
                    end
                end
                xfer_done && state == S_ACCESS: begin
                    out_valid    <= 1'b1;
                    out_op       <= cur_op;
                    out_dest     <= cur_rega;
                    out_rf_write <= cur_load;
                    if (cur_load) begin
                        out_wdata     <= dmem_rdata;
                        out_ccr_write <= 1'b0;
                        out_ccr_value <= {dmem_rdata == '0,
                                          cur_carry};
                    end else begin
                        out_wdata     <= '0;
                        out_ccr_write <= 1'b1;
                        out_ccr_value <= '0;
                    end
                end
                xfer_done && state == S_MULTI: begin
                    out_valid     <= 1'b1;
                    out_op        <= cur_op;
                    out_dest      <= idx;
                    out_rf_write  <= cur_load;
                    out_wdata     <= cur_load ? dmem_rdata
                                              : rf_rd_data;
                    out_ccr_write <= 1'b1;
                    out_ccr_value <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: directed + randomized bench for mem_stage_ctrl,
// checked against a transaction-level model of the memory stage.
module tb_mem_stage_ctrl;

    localparam int DW = 16;
`ifdef MEM_STAGE_TIMEOUT_EN
    localparam int WL = 4;
`else
    localparam int WL = 64;
`endif
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_ADI = 4'd1;
    localparam logic [3:0] OP_NDU = 4'd2;
    localparam logic [3:0] OP_LW  = 4'd4;
    localparam logic [3:0] OP_SW  = 4'd5;
    localparam logic [3:0] OP_LM  = 4'd6;
    localparam logic [3:0] OP_SM  = 4'd7;

    typedef struct {
        logic [5:0]  op;
        logic [2:0]  dest;
        logic [15:0] wdata;
        logic        rfw;
        logic        ccrw;
        logic [1:0]  ccrv;
        int          cyc;
    } ent_t;

    typedef struct {
        ent_t e;
        bit   c_dest;
        bit   c_wdata;
        bit   c_ccrw;
        bit   c_ccrv;
    } exp_t;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [15:0] wdata;
    } req_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [5:0]    in_op;
    logic [2:0]    in_regA, in_regC;
    logic [7:0]    in_imm8;
    logic [DW-1:0] in_alu_out, in_ra_out;
    logic          in_ccr_write;
    logic [1:0]    in_ccr_value;
    logic          stall;
    logic [DW-1:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic          dmem_re, dmem_we, dmem_ready;
    logic [2:0]    rf_rd_addr;
    logic [DW-1:0] rf_rd_data;
    logic          out_valid;
    logic [5:0]    out_op;
    logic [2:0]    out_dest;
    logic [DW-1:0] out_wdata;
    logic          out_rf_write, out_ccr_write;
    logic [1:0]    out_ccr_value;
    logic          bus_err;

    logic [15:0] mem     [0:65535];
    logic [15:0] ref_mem [0:65535];
    logic [15:0] rf      [0:7];
    int          wv      [0:7];

    ent_t obs_q[$];
    req_t req_q[$];
    int   cyc = 0;
    int   op_seq = 0;
    int   both_err, we_cnt, stall_cnt, unstable;
    int   nvec, nerr;

    mem_stage_ctrl #(.DATA_W(DW), .WAIT_LIMIT(WL)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_op(in_op),
        .in_regA(in_regA), .in_regC(in_regC),
        .in_imm8(in_imm8), .in_alu_out(in_alu_out),
        .in_ra_out(in_ra_out), .in_ccr_write(in_ccr_write),
        .in_ccr_value(in_ccr_value), .stall(stall),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_re(dmem_re), .dmem_we(dmem_we),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
        .out_valid(out_valid), .out_op(out_op),
        .out_dest(out_dest), .out_wdata(out_wdata),
        .out_rf_write(out_rf_write),
        .out_ccr_write(out_ccr_write),
        .out_ccr_value(out_ccr_value), .bus_err(bus_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign rf_rd_data = rf[rf_rd_addr];

    function automatic logic [15:0] init_word(int i);
        if (i == 16) return 16'h0000;
        return 16'((i * 40503) ^ 23130);
    endfunction

    function automatic exp_t mk(logic [5:0] op, logic [2:0] d,
        logic [15:0] w, logic rfw, logic cw, logic [1:0] cv,
        int lat, bit cd, bit cwd, bit ccw, bit ccv);
        exp_t x;
        x.e = '{op, d, w, rfw, cw, cv, lat};
        x.c_dest = cd;
        x.c_wdata = cwd;
        x.c_ccrw = ccw;
        x.c_ccrv = ccv;
        return x;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory responder: per-transfer wait counts come from wv[],
    // restarted for every new op; logs completed requests and entries.
    initial begin : responder
        int xfer, seen, cur_wait;
        bit in_req;
        logic [15:0] a0;
        for (int i = 0; i < 65536; i++) mem[i] = init_word(i);
        dmem_ready = 1'b0;
        dmem_rdata = '0;
        both_err = 0; we_cnt = 0; stall_cnt = 0; unstable = 0;
        xfer = 0; seen = -1; cur_wait = 0; in_req = 0; a0 = '0;
        forever begin
            @(negedge clk);
            if (dmem_re && dmem_we) both_err++;
            if (dmem_we) we_cnt++;
            if (stall) stall_cnt++;
            if (out_valid)
                obs_q.push_back('{out_op, out_dest, out_wdata,
                    out_rf_write, out_ccr_write, out_ccr_value, cyc});
            if (dmem_re || dmem_we) begin
                if (!in_req) begin
                    if (op_seq != seen) begin
                        seen = op_seq;
                        xfer = 0;
                    end
                    cur_wait = (xfer < 8) ? wv[xfer] : 0;
                    xfer++;
                    in_req = 1;
                    a0 = dmem_addr;
                end else if (dmem_addr !== a0) unstable++;
                if (cur_wait == 0) begin
                    dmem_ready = 1'b1;
                    dmem_rdata = mem[dmem_addr];
                    req_q.push_back('{dmem_addr, dmem_we, dmem_wdata});
                    if (dmem_we) mem[dmem_addr] = dmem_wdata;
                    in_req = 0;
                end else begin
                    dmem_ready = 1'b0;
                    dmem_rdata = 16'($urandom);
                    cur_wait--;
                end
            end else begin
                in_req = 0;
                dmem_ready = 1'b0;
            end
        end
    end

    task automatic scramble();
        in_op = 6'($urandom);
        in_regA = 3'($urandom);
        in_regC = 3'($urandom);
        in_imm8 = 8'($urandom);
        in_alu_out = 16'($urandom);
        in_ra_out = 16'($urandom);
        in_ccr_write = 1'($urandom);
        in_ccr_value = 2'($urandom);
    endtask

    task automatic do_op(input string tag, input logic [3:0] opc,
        input logic [1:0] lo, input logic [2:0] ra,
        input logic [2:0] rc, input logic [7:0] imm,
        input logic [15:0] alu, input logic [15:0] rad,
        input logic ccw, input logic [1:0] ccv);
        exp_t ex[$];
        req_t er[$];
        ent_t o;
        logic [5:0] op;
        logic [15:0] a;
        int lat, sum, k, ob, rb, sb, wb, acc, nob, nrq;
        bit wr;
        op = {opc, lo};
        lat = 1; sum = 0; k = 0;
        wr = opc == OP_SW || opc == OP_SM;
        case (opc)
            OP_LW, OP_SW: begin
                sum = wv[0] + 1;
                lat = lat + sum;
                er.push_back('{alu, wr, rad});
                if (opc == OP_LW) begin
                    ex.push_back(mk(op, ra, ref_mem[alu], 1, 0,
                        {ref_mem[alu] == 16'h0, ccv[0]}, lat,
                        1, 1, 1, 1));
                end else begin
                    ref_mem[alu] = rad;
                    ex.push_back(mk(op, 0, 0, 0, 1, 0, lat,
                        0, 0, 1, 0));
                end
            end
            OP_LM, OP_SM: begin
                for (int i = 0; i < 8; i++) begin
                    if (imm[i]) begin
                        a = alu + 16'(k);
                        sum = sum + wv[k] + 1;
                        lat = lat + wv[k] + 1;
                        if (opc == OP_LM) begin
                            er.push_back('{a, 1'b0, 16'h0});
                            ex.push_back(mk(op, 3'(i), ref_mem[a],
                                1, 1, 0, lat, 1, 1, 1, 0));
                        end else begin
                            er.push_back('{a, 1'b1, rf[i]});
                            ref_mem[a] = rf[i];
                            ex.push_back(mk(op, 3'(i), rf[i],
                                0, 1, 0, lat, 0, 0, 0, 0));
                        end
                        k++;
                    end
                end
                if (k == 0)
                    ex.push_back(mk(op, 0, 0, 0, 1, 0, 1,
                        0, 0, 0, 0));
            end
            default:
                ex.push_back(mk(op, rc, alu, 1, ccw, ccv, 1,
                    1, 1, 1, 1));
        endcase
        op_seq++;
        @(negedge clk);
        #1;
        ob = obs_q.size(); rb = req_q.size();
        sb = stall_cnt; wb = we_cnt; acc = cyc;
        in_valid = 1'b1; in_op = op; in_regA = ra; in_regC = rc;
        in_imm8 = imm; in_alu_out = alu; in_ra_out = rad;
        in_ccr_write = ccw; in_ccr_value = ccv;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        scramble();
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            #1;
            if (obs_q.size() - ob >= ex.size() && !stall) break;
        end
        @(negedge clk);
        #1;
        nob = obs_q.size() - ob;
        nrq = req_q.size() - rb;
        check({tag, "/entries"}, nob, ex.size());
        for (int j = 0; j < ex.size() && j < nob; j++) begin
            o = obs_q[ob + j];
            check({tag, "/op"}, o.op, ex[j].e.op);
            check({tag, "/rf_write"}, o.rfw, ex[j].e.rfw);
            check({tag, "/latency"}, o.cyc - acc, ex[j].e.cyc);
            if (ex[j].c_dest)
                check({tag, "/dest"}, o.dest, ex[j].e.dest);
            if (ex[j].c_wdata)
                check({tag, "/wdata"}, o.wdata, ex[j].e.wdata);
            if (ex[j].c_ccrw)
                check({tag, "/ccr_write"}, o.ccrw, ex[j].e.ccrw);
            if (ex[j].c_ccrv)
                check({tag, "/ccr_value"}, o.ccrv, ex[j].e.ccrv);
        end
        check({tag, "/requests"}, nrq, er.size());
        for (int j = 0; j < er.size() && j < nrq; j++) begin
            check({tag, "/req_addr"}, req_q[rb + j].addr, er[j].addr);
            check({tag, "/req_we"}, req_q[rb + j].we, er[j].we);
            if (er[j].we)
                check({tag, "/req_wdata"}, req_q[rb + j].wdata,
                      er[j].wdata);
        end
        check({tag, "/stall_cycles"}, stall_cnt - sb, sum);
        check({tag, "/we_cycles"}, we_cnt - wb, wr ? sum : 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [3:0] opc;
        logic [7:0] m;
        logic [15:0] base;
        int ob;
        nvec = 0; nerr = 0;
        reset = 1'b1;
        in_valid = 1'b0;
        scramble();
        for (int i = 0; i < 8; i++) begin
            wv[i] = 0;
            rf[i] = 16'($urandom);
        end
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_word(i);
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst/out_valid", out_valid, 0);
        check("rst/stall", stall, 0);
        check("rst/dmem_re", dmem_re, 0);
        check("rst/dmem_we", dmem_we, 0);
        check("rst/ccr_write", out_ccr_write, 1);
        check("rst/out_wdata", out_wdata, 0);
        check("rst/out_dest", out_dest, 0);
        check("rst/bus_err", bus_err, 0);
        reset = 1'b1;

        wv[0] = 2;
        do_op("lw_wait2", OP_LW, 2'd0, 3'd5, 3'd1, 8'h00,
              16'h0010, 16'h0, 1'b1, 2'b01);
        wv[0] = 0;
        do_op("sw_beef", OP_SW, 2'd0, 3'd2, 3'd1, 8'h00,
              16'h0020, 16'hBEEF, 1'b1, 2'b00);
        do_op("lm_wrap", OP_LM, 2'd0, 3'd1, 3'd0, 8'h85,
              16'hFFFE, 16'h0, 1'b1, 2'b00);
        do_op("sm_mask0", OP_SM, 2'd0, 3'd1, 3'd0, 8'h00,
              16'h1234, 16'h0, 1'b1, 2'b00);
        do_op("add", OP_ADD, 2'd0, 3'd1, 3'd6, 8'h00,
              16'h7777, 16'h0, 1'b0, 2'b10);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 6))
                0: opc = OP_ADD;
                1: opc = OP_ADI;
                2: opc = OP_NDU;
                3: opc = OP_LW;
                4: opc = OP_SW;
                5: opc = OP_LM;
                default: opc = OP_SM;
            endcase
            m = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            base = ($urandom_range(0, 3) == 0)
                 ? 16'($urandom_range(16'hFFF8, 16'hFFFF))
                 : 16'($urandom);
            for (int i = 0; i < 8; i++) wv[i] = $urandom_range(0, 3);
            do_op("rand", opc, 2'($urandom), 3'($urandom),
                  3'($urandom), m, base, 16'($urandom),
                  1'($urandom), 2'($urandom));
        end

        for (int i = 0; i < 8; i++) wv[i] = 0;
        op_seq++;
        @(negedge clk);
        #1;
        in_valid = 1'b1; in_op = {OP_LM, 2'b00}; in_regA = 3'd0;
        in_imm8 = 8'hFF; in_alu_out = 16'($urandom);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        ob = obs_q.size();
        check("rstmid/dmem_re", dmem_re, 0);
        check("rstmid/out_valid", out_valid, 0);
        check("rstmid/stall", stall, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        check("rstmid/no_more_entries", obs_q.size() - ob, 0);
        check("rstmid/idle_re", dmem_re, 0);
        wv[0] = 1;
        do_op("lw_after_rst", OP_LW, 2'd1, 3'd3, 3'd0, 8'h00,
              16'($urandom), 16'h0, 1'b1, 2'b11);

`ifdef MEM_STAGE_TIMEOUT_EN
        begin
            int sb;
            wv[0] = 1000;
            op_seq++;
            @(negedge clk);
            #1;
            ob = obs_q.size();
            sb = stall_cnt;
            in_valid = 1'b1; in_op = {OP_LW, 2'b00};
            in_alu_out = 16'h0040;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            for (int t = 0; t < 50; t++) begin
                @(negedge clk);
                #1;
                if (!stall) break;
            end
            repeat (2) @(negedge clk);
            #1;
            check("timeout/stall_cycles", stall_cnt - sb, WL);
            check("timeout/entries", obs_q.size() - ob, 0);
            check("timeout/stall", stall, 0);
        end
        check("final/bus_err", bus_err, 1);
`else
        check("final/bus_err", bus_err, 0);
`endif
        check("final/re_we_both", both_err, 0);
        check("final/req_unstable", unstable, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nerr);
        $finish;
    end

endmodule
